thread_scheduler: RTL and testbench

Parametrised round-robin thread selector for the barrel core. It generalises the free-running 2-bit thread timer and drives the register-file and PC-bank select.
- N threads, programmable time slice per thread.
- Per-thread enable mask; disabled threads are skipped.
- Pipeline hold input freezes the current selection.
- With defaults (4 threads, slice 1, all enabled) the sequence is 0,1,2,3,0,..., so it is a drop-in for the previous timer.

---
 rtl/thread_scheduler.sv | 93 +++++++++
 tb/tb_thread_scheduler.sv | 135 +++++++++++++
 2 files changed

// File: rtl/thread_scheduler.sv
// rtl/thread_scheduler.sv - round-robin thread selector with per-thread enable, time slice and hold
module thread_scheduler #(
    parameter int NUM_THREADS = 4,
    parameter int TID_W       = $clog2(NUM_THREADS),
    parameter int SLICE_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_THREADS-1:0] thread_en_i,
    input  logic [SLICE_W-1:0]     slice_len_i,
    input  logic                   hold_i,
    output logic [TID_W-1:0]       thread_id_o,
    output logic                   switch_o,
    output logic                   idle_o,
    output logic [SLICE_W-1:0]     slice_cnt_o
);

    logic [TID_W-1:0]   thread_id_q, thread_id_d;
    logic [SLICE_W-1:0] slice_cnt_q, slice_cnt_d;
    logic               switch_q, switch_d;
    logic               idle_q, idle_d;

    logic [SLICE_W-1:0] last_cnt;
    logic [TID_W-1:0]   next_id;
    logic [TID_W-1:0]   cand;
    logic               found;
    logic               slice_end;
    int                 idx;

    // Length 0 behaves as 1, so the last count of the slice is 0 in both cases.
    assign last_cnt  = (slice_len_i == '0) ? '0 : slice_len_i - 1'b1;
    assign slice_end = (slice_cnt_q >= last_cnt) || !thread_en_i[thread_id_q];

    // Search cur+1, cur+2, ... and finally cur itself; wraps at NUM_THREADS.
    always_comb begin
        next_id = thread_id_q;
        found   = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            idx = int'(thread_id_q) + k;
            if (idx >= NUM_THREADS) begin
                idx = idx - NUM_THREADS;
            end
            cand = TID_W'(idx);
            if (!found && thread_en_i[cand]) begin
                found   = 1'b1;
                next_id = cand;
            end
        end
    end

    always_comb begin
        thread_id_d = thread_id_q;
        slice_cnt_d = slice_cnt_q;
        switch_d    = 1'b0;
        idle_d      = idle_q;
        if (hold_i) begin
            idle_d = idle_q;
        end else if (thread_en_i == '0) begin
            slice_cnt_d = '0;
            idle_d      = 1'b1;
        end else if (slice_end) begin
            thread_id_d = next_id;
            slice_cnt_d = '0;
            idle_d      = 1'b0;
            switch_d    = (next_id != thread_id_q);
        end else begin
            slice_cnt_d = slice_cnt_q + 1'b1;
            idle_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            thread_id_q <= '0;
            slice_cnt_q <= '0;
            switch_q    <= 1'b0;
            idle_q      <= 1'b0;
        end else begin
            thread_id_q <= thread_id_d;
            slice_cnt_q <= slice_cnt_d;
            switch_q    <= switch_d;
            idle_q      <= idle_d;
        end
    end

    assign thread_id_o = thread_id_q;
    assign slice_cnt_o = slice_cnt_q;
    assign switch_o    = switch_q;
    assign idle_o      = idle_q;

endmodule

// File: tb/tb_thread_scheduler.sv
// tb/tb_thread_scheduler.sv - directed scoreboard bench for thread_scheduler (4-thread and 3-thread instances)
module tb_thread_scheduler;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, hold4, sw4, idle4;
    logic [3:0] en4, len4, cnt4;
    logic [1:0] id4;

    logic       rst3, hold3, sw3, idle3;
    logic [2:0] en3;
    logic [3:0] len3, cnt3;
    logic [1:0] id3;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] exp_q[$];
    string      tag_q[$];

    thread_scheduler #(.NUM_THREADS(4), .SLICE_W(4)) u_dut4 (
        .clk(clk), .rst(rst4), .thread_en_i(en4), .slice_len_i(len4), .hold_i(hold4),
        .thread_id_o(id4), .switch_o(sw4), .idle_o(idle4), .slice_cnt_o(cnt4)
    );

    thread_scheduler #(.NUM_THREADS(3), .SLICE_W(4)) u_dut3 (
        .clk(clk), .rst(rst3), .thread_en_i(en3), .slice_len_i(len3), .hold_i(hold3),
        .thread_id_o(id3), .switch_o(sw3), .idle_o(idle3), .slice_cnt_o(cnt3)
    );

    task automatic check();
        logic [8:0] e;
        logic [7:0] obs;
        string      t;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        obs = e[8] ? {id3, sw3, idle3, cnt3} : {id4, sw4, idle4, cnt4};
        n_tests++;
        assert (obs === e[7:0]) else begin
            n_fail++;
            $error("FAIL %s: observed id=%0d sw=%0d idle=%0d cnt=%0d, expected id=%0d sw=%0d idle=%0d cnt=%0d",
                   t, obs[7:6], obs[5], obs[4], obs[3:0], e[7:6], e[5], e[4], e[3:0]);
        end
    endtask

    task automatic step4(input logic r, input logic [3:0] en, input logic [3:0] len, input logic h,
                         input logic [1:0] id, input logic sw, input logic idl, input logic [3:0] cnt,
                         input string tag);
        rst4 = r; en4 = en; len4 = len; hold4 = h;
        exp_q.push_back({1'b0, id, sw, idl, cnt});
        tag_q.push_back(tag);
        @(posedge clk); #1;
        check();
    endtask

    task automatic step3(input logic r, input logic [2:0] en, input logic h,
                         input logic [1:0] id, input logic sw, input logic idl, input logic [3:0] cnt,
                         input string tag);
        rst3 = r; en3 = en; len3 = 4'd1; hold3 = h;
        exp_q.push_back({1'b1, id, sw, idl, cnt});
        tag_q.push_back(tag);
        @(posedge clk); #1;
        check();
    endtask

    initial begin
        rst4 = 1'b1; en4 = 4'hF; len4 = 4'd1; hold4 = 1'b0;
        rst3 = 1'b1; en3 = 3'b111; len3 = 4'd1; hold3 = 1'b0;

        step4(1, 4'hF, 4'd1, 0, 2'd0, 0, 0, 4'd0, "reset4");
        step4(1, 4'hF, 4'd1, 0, 2'd0, 0, 0, 4'd0, "reset4b");

        step4(0, 4'hF, 4'd1, 0, 2'd1, 1, 0, 4'd0, "dropin");
        step4(0, 4'hF, 4'd1, 0, 2'd2, 1, 0, 4'd0, "dropin");
        step4(0, 4'hF, 4'd1, 0, 2'd3, 1, 0, 4'd0, "dropin");
        step4(0, 4'hF, 4'd1, 0, 2'd0, 1, 0, 4'd0, "dropin_wrap");
        step4(0, 4'hF, 4'd1, 0, 2'd1, 1, 0, 4'd0, "dropin");
        step4(0, 4'hF, 4'd1, 0, 2'd2, 1, 0, 4'd0, "dropin");

        step4(0, 4'hF, 4'd3, 0, 2'd2, 0, 0, 4'd1, "slice3");
        step4(0, 4'hF, 4'd3, 0, 2'd2, 0, 0, 4'd2, "slice3");
        step4(0, 4'hF, 4'd3, 0, 2'd3, 1, 0, 4'd0, "slice3_sw");
        step4(0, 4'hF, 4'd3, 0, 2'd3, 0, 0, 4'd1, "slice3");
        step4(0, 4'hF, 4'd3, 0, 2'd3, 0, 0, 4'd2, "slice3");
        step4(0, 4'hF, 4'd3, 0, 2'd0, 1, 0, 4'd0, "slice3_sw");

        step4(0, 4'hF, 4'd0, 0, 2'd1, 1, 0, 4'd0, "slice0");
        step4(0, 4'hF, 4'd0, 0, 2'd2, 1, 0, 4'd0, "slice0");
        step4(0, 4'hF, 4'd0, 0, 2'd3, 1, 0, 4'd0, "slice0");

        step4(0, 4'b1010, 4'd1, 0, 2'd1, 1, 0, 4'd0, "skip");
        step4(0, 4'b1010, 4'd1, 0, 2'd3, 1, 0, 4'd0, "skip");
        step4(0, 4'b1010, 4'd1, 0, 2'd1, 1, 0, 4'd0, "skip");
        step4(0, 4'b1010, 4'd1, 0, 2'd3, 1, 0, 4'd0, "skip");
        step4(0, 4'b0010, 4'd4, 0, 2'd1, 1, 0, 4'd0, "disable_cur");

        step4(0, 4'b0100, 4'd1, 0, 2'd2, 1, 0, 4'd0, "single_enter");
        step4(0, 4'b0100, 4'd1, 0, 2'd2, 0, 0, 4'd0, "single_self");
        step4(0, 4'b0100, 4'd1, 0, 2'd2, 0, 0, 4'd0, "single_self");
        step4(0, 4'b0000, 4'd1, 0, 2'd2, 0, 1, 4'd0, "idle");
        step4(0, 4'b0000, 4'd1, 0, 2'd2, 0, 1, 4'd0, "idle");
        step4(0, 4'b0001, 4'd1, 0, 2'd0, 1, 0, 4'd0, "leave_idle");

        step4(0, 4'hF, 4'd2, 0, 2'd0, 0, 0, 4'd1, "pre_hold");
        step4(0, 4'hF, 4'd2, 0, 2'd1, 1, 0, 4'd0, "pre_hold");
        step4(0, 4'hF, 4'd2, 0, 2'd1, 0, 0, 4'd1, "pre_hold");
        for (int i = 0; i < 5; i++)
            step4(0, 4'hF, 4'd2, 1, 2'd1, 0, 0, 4'd1, "hold");
        step4(0, 4'hF, 4'd2, 0, 2'd2, 1, 0, 4'd0, "hold_release");

        step4(0, 4'hF, 4'd4, 0, 2'd2, 0, 0, 4'd1, "len4");
        step4(0, 4'hF, 4'd4, 0, 2'd2, 0, 0, 4'd2, "len4");
        step4(0, 4'hF, 4'd2, 0, 2'd3, 1, 0, 4'd0, "len_shrink");

        step4(0, 4'b0000, 4'd1, 0, 2'd3, 0, 1, 4'd0, "idle2");
        step4(0, 4'hF,    4'd1, 1, 2'd3, 0, 1, 4'd0, "hold_keeps_idle");
        step4(0, 4'hF,    4'd1, 0, 2'd0, 1, 0, 4'd0, "idle_exit");
        step4(1, 4'hF,    4'd1, 1, 2'd0, 0, 0, 4'd0, "rst_in_hold4");

        step3(1, 3'b111, 0, 2'd0, 0, 0, 4'd0, "reset3");
        step3(0, 3'b111, 0, 2'd1, 1, 0, 4'd0, "n3");
        step3(0, 3'b111, 0, 2'd2, 1, 0, 4'd0, "n3");
        step3(0, 3'b111, 0, 2'd0, 1, 0, 4'd0, "n3_wrap");
        step3(0, 3'b111, 0, 2'd1, 1, 0, 4'd0, "n3");
        step3(0, 3'b111, 0, 2'd2, 1, 0, 4'd0, "n3");
        step3(0, 3'b111, 1, 2'd2, 0, 0, 4'd0, "n3_hold");
        step3(1, 3'b111, 1, 2'd0, 0, 0, 4'd0, "n3_rst_in_hold");
        step3(0, 3'b111, 0, 2'd1, 1, 0, 4'd0, "n3_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
